pipeline_stall_ctrl: RTL and testbench

- Central sequencer for the five-stage pipeline registers: drives the write-enable and synchronous-flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three events:
  - load-use hazards, by inserting one bubble;
  - taken branches and jumps, by flushing two stages;
  - multi-cycle data-memory accesses, by freezing the whole pipeline through a small FSM with a latency counter.
- Also keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_stall_ctrl.sv | 137 +++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush sequencer for the five-stage core.
// Produces write-enables and synchronous flushes for the PC, IF/ID, ID/EX,
// EX/MEM and MEM/WB registers from load-use hazards, taken branches and
// multi-cycle data-memory accesses. Also keeps a saturating stall counter.
// ctrl_state exposes the memory-wait FSM (0=RUN, 1=MEM_WAIT, 2=MEM_DONE).
// Note: the we/flush outputs are combinational from state and inputs,
// because hazards must be resolved in the cycle they are seen. The FSM
// state, the wait counter and stall_cycles are registered.
module pipeline_stall_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_LAT    = 3,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_access,
    output logic                  pc_we,
    output logic                  ifid_we,
    output logic                  ifid_flush,
    output logic                  idex_we,
    output logic                  idex_flush,
    output logic                  exmem_we,
    output logic                  memwb_we,
    output logic [1:0]            ctrl_state,
    output logic [CNT_W-1:0]      stall_cycles
);

    // A single-cycle memory never needs to freeze the pipeline.
    localparam bit MULTI_CYCLE = (MEM_LAT > 1);
    // The wait counter is preloaded with MEM_LAT-2; keep it at least 1 bit wide.
    localparam int WAIT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((MEM_LAT > 2) ? (MEM_LAT - 2) : 0);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MEM_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lu;
    logic              mem_start;
    logic              freeze;

    // Load in EX writes a register the ID instruction reads (x0 never hazards).
    assign lu = ex_mem_read && (ex_rd != '0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd)));

    // A memory access starts a freeze only from RUN; in MEM_DONE the same
    // instruction is still in MEM and must not retrigger.
    assign mem_start = MULTI_CYCLE && (state == ST_RUN) && mem_access;
    assign freeze    = (state == ST_MEM_WAIT) || mem_start;

    assign ctrl_state = state;

    // Memory-wait FSM: counts out the remaining access latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_start) begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= (MEM_LAT == 2) ? ST_MEM_DONE : ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (wait_cnt == WAIT_W'(1)) begin
                        state <= ST_MEM_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_MEM_DONE: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Output priority: reset, freeze, branch flush, load-use bubble, normal flow.
    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_we    = 1'b1;
        idex_flush = 1'b0;
        exmem_we   = 1'b1;
        memwb_we   = 1'b1;
        if (!rst) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_we    = 1'b0;
            idex_flush = 1'b1;
            exmem_we   = 1'b0;
            memwb_we   = 1'b0;
        end else if (freeze) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_we = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (!pc_we && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl. Four instances share one stimulus stream:
// MEM_LAT=3, MEM_LAT=2, MEM_LAT=1, and MEM_LAT=3 with a 3-bit stall counter
// so that saturation is reached. The reference model tracks how many more
// cycles the current memory instruction occupies MEM and derives outputs
// from the priority rules directly.
// Output vector order: {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we}.
module tb_pipeline_stall_ctrl;

  localparam int N = 4;
  localparam logic [6:0] O_RESET  = 7'b0010100;
  localparam logic [6:0] O_FREEZE = 7'b0000000;
  localparam logic [6:0] O_BRANCH = 7'b1111111;
  localparam logic [6:0] O_LU     = 7'b0001111;
  localparam logic [6:0] O_NORMAL = 7'b1101011;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_access;

  logic [6:0]  outv [N];
  logic [1:0]  st   [N];
  logic [31:0] sc   [N];

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] exp_q[$];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L  = (g == 0) ? 3 : (g == 1) ? 2 : (g == 2) ? 1 : 3;
    localparam int CW = (g == 3) ? 3 : 32;
    logic pc_we_s, ifid_we_s, ifid_flush_s, idex_we_s, idex_flush_s, exmem_we_s, memwb_we_s;
    logic [1:0]    st_s;
    logic [CW-1:0] sc_s;
    pipeline_stall_ctrl #(.REG_ADDR_W(5), .MEM_LAT(L), .CNT_W(CW)) u_dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .ex_branch_taken(ex_branch_taken), .mem_access(mem_access),
      .pc_we(pc_we_s), .ifid_we(ifid_we_s), .ifid_flush(ifid_flush_s),
      .idex_we(idex_we_s), .idex_flush(idex_flush_s),
      .exmem_we(exmem_we_s), .memwb_we(memwb_we_s),
      .ctrl_state(st_s), .stall_cycles(sc_s)
    );
    assign outv[g] = {pc_we_s, ifid_we_s, ifid_flush_s, idex_we_s, idex_flush_s, exmem_we_s, memwb_we_s};
    assign st[g]   = st_s;
    assign sc[g]   = 32'(sc_s);
  end

  // ---------------- reference model ----------------
  int     m_busy  [N];
  longint m_stall [N];

  function automatic int lat_of(int g);
    return (g == 0) ? 3 : (g == 1) ? 2 : (g == 2) ? 1 : 3;
  endfunction

  function automatic longint sat_of(int g);
    return (g == 3) ? 64'd7 : 64'hFFFF_FFFF;
  endfunction

  function automatic logic [6:0] model_out(int g);
    logic lu_m;
    if (!rst) return O_RESET;
    if (m_busy[g] > 1) return O_FREEZE;
    if (m_busy[g] == 0 && lat_of(g) > 1 && mem_access) return O_FREEZE;
    if (ex_branch_taken) return O_BRANCH;
    lu_m = ex_mem_read && (ex_rd != 0) &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (lu_m) return O_LU;
    return O_NORMAL;
  endfunction

  function automatic logic [1:0] model_state(int g);
    if (m_busy[g] == 0) return 2'd0;
    if (m_busy[g] == 1) return 2'd2;
    return 2'd1;
  endfunction

  always @(posedge clk or negedge rst) begin : model_p
    logic [6:0] mo;
    for (int g = 0; g < N; g++) begin
      if (!rst) begin
        m_busy[g]  = 0;
        m_stall[g] = 0;
      end else begin
        mo = model_out(g);
        if (!mo[6] && m_stall[g] < sat_of(g)) m_stall[g] = m_stall[g] + 1;
        if (m_busy[g] > 0) m_busy[g] = m_busy[g] - 1;
        else if (mem_access && lat_of(g) > 1) m_busy[g] = lat_of(g) - 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0;
    ex_branch_taken = 0; mem_access = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
    ex_mem_read = 1; ex_rd = rd;
    id_rs1 = rs1; id_uses_rs1 = u1;
    id_rs2 = rs2; id_uses_rs2 = u2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_idle();
    rst = 0;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      vectors++;
      if (outv[g] !== O_RESET) begin
        miscompares++;
        $display("FAIL reset_outputs[%0d]: got %b want %b", g, outv[g], O_RESET);
      end
      vectors++;
      if (st[g] !== 2'd0 || sc[g] !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_state[%0d]: state %0d stall %0d want 0/0", g, st[g], sc[g]);
      end
    end
    next_cycle();
    rst = 1;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      vectors++;
      if (outv[g] !== O_NORMAL) begin
        miscompares++;
        $display("FAIL release_idle[%0d]: got %b want %b", g, outv[g], O_NORMAL);
      end
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    longint s0;
    s0 = m_stall[0];
    drive_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (outv[0] !== O_LU) begin
      miscompares++;
      $display("FAIL load_use_rs1: got %b want %b", outv[0], O_LU);
    end
    next_cycle();
    drive_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    vectors++;
    if (sc[0] !== 32'(s0 + 1)) begin
      miscompares++;
      $display("FAIL load_use_count: got %0d want %0d", sc[0], s0 + 1);
    end
    vectors++;
    if (outv[0] !== O_NORMAL) begin
      miscompares++;
      $display("FAIL load_use_rd0: got %b want %b", outv[0], O_NORMAL);
    end
    next_cycle();
    drive_lu(5'd5, 5'd5, 1'b0, 5'd3, 1'b1);
    @(negedge clk);
    vectors++;
    if (outv[0] !== O_NORMAL) begin
      miscompares++;
      $display("FAIL load_use_unused_rs1: got %b want %b", outv[0], O_NORMAL);
    end
    next_cycle();
    drive_lu(5'd7, 5'd1, 1'b0, 5'd7, 1'b1);
    @(negedge clk);
    vectors++;
    if (outv[0] !== O_LU) begin
      miscompares++;
      $display("FAIL load_use_rs2: got %b want %b", outv[0], O_LU);
    end
    next_cycle();
    set_idle();
    @(negedge clk);
    vectors++;
    if (sc[0] !== 32'(s0 + 2)) begin
      miscompares++;
      $display("FAIL load_use_count2: got %0d want %0d", sc[0], s0 + 2);
    end
    next_cycle();
  endtask

  task automatic test_branch_over_lu();
    longint s0;
    s0 = m_stall[0];
    drive_lu(5'd9, 5'd9, 1'b1, 5'd9, 1'b1);
    ex_branch_taken = 1;
    @(negedge clk);
    vectors++;
    if (outv[0] !== O_BRANCH) begin
      miscompares++;
      $display("FAIL branch_over_lu: got %b want %b", outv[0], O_BRANCH);
    end
    next_cycle();
    set_idle();
    @(negedge clk);
    vectors++;
    if (sc[0] !== 32'(s0)) begin
      miscompares++;
      $display("FAIL branch_no_stall_count: got %0d want %0d", sc[0], s0);
    end
    next_cycle();
  endtask

  task automatic test_mem_freeze();
    longint s_before [3];
    logic [8:0] e;
    int L, ph;
    for (int g = 0; g < 3; g++) s_before[g] = m_stall[g];
    // expected {state, outputs} per cycle from the occupancy rule:
    // an access holds MEM for L cycles, the last of which is MEM_DONE.
    for (int c = 0; c < 6; c++) begin
      for (int g = 0; g < 3; g++) begin
        L = lat_of(g);
        ph = c % L;
        if (L == 1)          exp_q.push_back({2'd0, O_NORMAL});
        else if (ph == L - 1) exp_q.push_back({2'd2, O_NORMAL});
        else if (ph == 0)    exp_q.push_back({2'd0, O_FREEZE});
        else                 exp_q.push_back({2'd1, O_FREEZE});
      end
    end
    set_idle();
    mem_access = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        e = exp_q.pop_front();
        vectors++;
        if ({st[g], outv[g]} !== e) begin
          miscompares++;
          $display("FAIL mem_freeze[%0d] cycle %0d: got st=%0d out=%b want st=%0d out=%b",
                   g, c, st[g], outv[g], e[8:7], e[6:0]);
        end
      end
      next_cycle();
    end
    mem_access = 0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      // lat 3: 2 freezes x2 accesses; lat 2: 1 freeze x3 accesses; lat 1: none
      vectors++;
      if (sc[g] !== 32'(s_before[g] + ((g == 0) ? 4 : (g == 1) ? 3 : 0))) begin
        miscompares++;
        $display("FAIL mem_freeze_count[%0d]: got %0d", g, sc[g]);
      end
    end
    next_cycle();
  endtask

  task automatic test_mem_branch();
    logic [6:0] want;
    set_idle();
    mem_access = 1;
    ex_branch_taken = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      want = (c < 2) ? O_FREEZE : O_BRANCH;
      vectors++;
      if (outv[0] !== want || st[0] !== 2'(c)) begin
        miscompares++;
        $display("FAIL mem_branch cycle %0d: got st=%0d out=%b want st=%0d out=%b",
                 c, st[0], outv[0], c, want);
      end
      next_cycle();
    end
    set_idle();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    set_idle();
    mem_access = 1;
    next_cycle();
    @(negedge clk);
    vectors++;
    if (st[0] !== 2'd1) begin
      miscompares++;
      $display("FAIL mid_wait_entry: state got %0d want 1", st[0]);
    end
    #1;
    rst = 0;
    #1;
    vectors++;
    if (st[0] !== 2'd0 || sc[0] !== 32'd0 || outv[0] !== O_RESET) begin
      miscompares++;
      $display("FAIL async_reset: state %0d stall %0d out %b", st[0], sc[0], outv[0]);
    end
    mem_access = 0;
    next_cycle();
    rst = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
        vectors++;
        if (outv[g] !== O_NORMAL || st[g] !== 2'd0 || sc[g] !== 32'd0) begin
          miscompares++;
          $display("FAIL after_reset[%0d] cycle %0d: out %b st %0d stall %0d", g, c, outv[g], st[g], sc[g]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_access      = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
        vectors++;
        if (outv[g] !== model_out(g)) begin
          miscompares++;
          $display("FAIL rand_out[%0d] n=%0d: got %b want %b", g, n, outv[g], model_out(g));
        end
        vectors++;
        if (st[g] !== model_state(g)) begin
          miscompares++;
          $display("FAIL rand_state[%0d] n=%0d: got %0d want %0d", g, n, st[g], model_state(g));
        end
        vectors++;
        if (sc[g] !== 32'(m_stall[g])) begin
          miscompares++;
          $display("FAIL rand_stall[%0d] n=%0d: got %0d want %0d", g, n, sc[g], m_stall[g]);
        end
      end
      next_cycle();
    end
    set_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    set_idle();
    test_reset();
    test_load_use();
    test_branch_over_lu();
    test_mem_freeze();
    test_mem_branch();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
